wb_master_arb: RTL and testbench
================================

WB_MASTER_ARB -- requirements
Module: wb_master_arb

Interface
REQ-001 Parameter NUM_CH, default 2: number of requester channels (IF, MEM, ...), legal range 1..8.
REQ-002 Parameter DATA_W, default 32: data/address width.
REQ-003 Parameter TIMEOUT_CYC, default 255: bus watchdog limit in cycles.
REQ-004 clk  in  1: single clock; reset is synchronous and active-high (rst).
REQ-005 rst  in  1: synchronous active-high reset.
REQ-006 flush_i  in  1: pipeline flush; aborts delivery of the in-flight result.
REQ-007 ch_req_i  in  NUM_CH: per-channel request, held until ch_ack_o.
REQ-008 ch_we_i  in  NUM_CH: per-channel write enable.
REQ-009 ch_addr_i / ch_data_i  in  NUM_CH*DATA_W: packed addresses / write data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-010 ch_sel_i  in  NUM_CH*DATA_W/8: packed byte selects.
REQ-011 ch_data_o  out  DATA_W: shared read data, valid with ch_ack_o.
REQ-012 ch_ack_o  out  NUM_CH: one-cycle completion pulse, one-hot.
REQ-013 ch_stall_o  out  NUM_CH: stall request to ctrl per channel.
REQ-014 wishbone_data_i, wishbone_ack_i  in  DATA_W, 1: slave read data, ack.
REQ-015 wishbone_addr_o, wishbone_data_o, wishbone_we_o, wishbone_sel_o, wishbone_stb_o, wishbone_cyc_o  out  DATA_W, DATA_W, 1, DATA_W/8, 1, 1: master signals, all registered.
REQ-016 err_o  out  1: one-cycle timeout pulse.

Function
REQ-017 FSM states IDLE, BUSY, DRAIN; encoding in the shared package.
REQ-018 IDLE: if any ch_req_i set and no ch_ack_o this cycle, grant by round-robin from pointer rr_ptr, latch that channel's we/addr/data/sel to wishbone outputs, assert stb/cyc next edge, go BUSY.
REQ-019 Round-robin: search starts at rr_ptr, wraps at NUM_CH-1 to 0; after each completion rr_ptr = granted+1 modulo NUM_CH.
REQ-020 BUSY with wishbone_ack_i and no flush_i: next edge deassert stb/cyc, ch_data_o = wishbone_data_i (reads; 0 for writes), ch_ack_o[granted]=1 for one cycle, go IDLE.
REQ-021 Minimum request-to-ack latency: 2 cycles after ch_req_i rise with zero-wait slave.
REQ-022 A channel whose ack pulsed is not re-granted in the same cycle; new grant earliest the cycle after ack.
REQ-023 ch_stall_o[i] = ch_req_i[i] & ~ch_ack_o[i], combinational.
REQ-024 flush_i in BUSY without ack: go DRAIN, keep stb/cyc until wishbone_ack_i, then drop them, no ch_ack_o, go IDLE.
REQ-025 flush_i and wishbone_ack_i in same BUSY cycle: flush wins; cycle ends, no ch_ack_o, go IDLE.
REQ-026 flush_i in IDLE: no grant that cycle.
REQ-027 Outputs stb/cyc never asserted when ch_req_i all zero in IDLE.

Reset
REQ-028 rst at any state, including mid-transaction: next edge state=IDLE, rr_ptr=0, stb/cyc/we=0, addr/data_o/sel=0, ch_data_o=0, ch_ack_o=0, err_o=0, watchdog=0.

Configuration
REQ-029 Macro WB_ARB_TIMEOUT_EN defined: watchdog counts cycles in BUSY/DRAIN, clears on entry; on reaching TIMEOUT_CYC drop stb/cyc, pulse err_o, in BUSY also pulse ch_ack_o[granted] with ch_data_o=0; go IDLE.
REQ-030 Macro undefined: no counter logic, err_o tied 0, transactions wait indefinitely.

Structure
REQ-031 Shared package/defines file holds FSM state constants, default parameter values and DATA_W/8 select-width constant.
REQ-032 One sub-module wb_rr_picker: combinational round-robin selector (req vector, rr_ptr -> one-hot grant, index).

Verification
REQ-033 Ch0 read 0x0000_0100, slave acks 1 cycle later with 0xDEADBEEF -> ch_ack_o=2'b01 pulse, ch_data_o=0xDEADBEEF, stb/cyc low next cycle.
REQ-034 Both channels request continuously, NUM_CH=2, rr_ptr=0 -> grants alternate 0,1,0,1 over four transactions.
REQ-035 Ch1 write 0x1234_5678 sel 4'b0011 -> wishbone_we_o=1, sel=0011, data_o=0x12345678; ch_ack_o=2'b10.
REQ-036 flush_i during BUSY, ack 3 cycles later -> stb/cyc held until ack, no ch_ack_o, IDLE after.
REQ-037 With WB_ARB_TIMEOUT_EN, TIMEOUT_CYC=8, no slave ack -> after 8 cycles err_o pulse, ch_ack_o pulse, ch_data_o=0.
REQ-038 rst asserted mid-BUSY -> next edge stb/cyc=0, rr_ptr=0, later wishbone_ack_i ignored.

Source files
------------

// File: rtl/wb_master_arb_pkg.sv
// wb_master_arb_pkg: FSM encoding, default parameters and width helpers shared by
// the arbiter, its round-robin picker and the bus interface.
package wb_master_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN} state_t;
  localparam int DEF_NUM_CH = 2;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_TIMEOUT_CYC = 255;
  localparam int DEF_SEL_W = DEF_DATA_W / 8;
  function automatic int idx_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int sel_w(int dw);
    return dw / 8;
  endfunction
endpackage

// File: rtl/wb_master_arb_if.sv
// wb_master_arb_if: Wishbone master-side bus bundle; master modport for the arbiter,
// slave modport for whatever answers the cycle.
interface wb_master_arb_if #(parameter int DATA_W = wb_master_arb_pkg::DEF_DATA_W);
  logic [DATA_W-1:0] wishbone_addr_o;
  logic [DATA_W-1:0] wishbone_data_o;
  logic [DATA_W-1:0] wishbone_data_i;
  logic [DATA_W/8-1:0] wishbone_sel_o;
  logic wishbone_we_o;
  logic wishbone_stb_o;
  logic wishbone_cyc_o;
  logic wishbone_ack_i;
  modport master (
    output wishbone_addr_o, wishbone_data_o, wishbone_sel_o, wishbone_we_o, wishbone_stb_o, wishbone_cyc_o,
    input  wishbone_data_i, wishbone_ack_i
  );
  modport slave (
    input  wishbone_addr_o, wishbone_data_o, wishbone_sel_o, wishbone_we_o, wishbone_stb_o, wishbone_cyc_o,
    output wishbone_data_i, wishbone_ack_i
  );
endinterface

// File: rtl/wb_rr_picker.sv
// wb_rr_picker: combinational round-robin selector; first set request at or after
// i_ptr (wrapping) wins, reported as one-hot grant and index.
module wb_rr_picker
  import wb_master_arb_pkg::*;
#(
  parameter int N = DEF_NUM_CH,
  localparam int IW = idx_w(N)
)(
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  logic w_found;
  int w_c;
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    w_found = 1'b0;
    w_c = 0;
    for (int k = 0; k < N; k++) begin
      w_c = (int'(i_ptr) + k) % N;
      if (!w_found && i_req[w_c]) begin
        w_found = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx = IW'(w_c);
      end
    end
  end
endmodule

// File: rtl/wb_master_arb.sv
// wb_master_arb: round-robin arbiter of NUM_CH requesters onto one Wishbone master port.
// Optional bus watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_master_arb
  import wb_master_arb_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [NUM_CH-1:0]          ch_req_i,
  input  logic [NUM_CH-1:0]          ch_we_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_addr_i,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_sel_i,
  output logic [DATA_W-1:0]          ch_data_o,
  output logic [NUM_CH-1:0]          ch_ack_o,
  output logic [NUM_CH-1:0]          ch_stall_o,
  output logic                       err_o,
  wb_master_arb_if.master            wb
);
  localparam int IW = idx_w(NUM_CH);
  localparam int SW = sel_w(DATA_W);
  state_t r_state, w_state_n;
  logic [IW-1:0] r_ptr, r_idx, w_idx;
  logic [NUM_CH-1:0] r_gnt, r_ack, w_gnt;
  logic [DATA_W-1:0] r_addr, r_wdat, r_rdat;
  logic [SW-1:0] r_sel;
  logic r_we, r_stb;
  logic w_grant, w_end, w_done, w_tmo;
  wb_rr_picker #(.N(NUM_CH)) u_pick (.i_req(ch_req_i), .i_ptr(r_ptr), .o_gnt(w_gnt), .o_idx(w_idx));
  // w_end: bus cycle finishes this edge; w_done: it also completes toward the requester
  always_comb begin
    w_state_n = r_state;
    w_grant = 1'b0;
    w_end = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant = |ch_req_i && !(|r_ack) && !flush_i;
        w_state_n = w_grant ? S_BUSY : S_IDLE;
      end
      S_BUSY: begin
        w_end = wb.wishbone_ack_i || (w_tmo && !flush_i);
        w_done = w_end && !flush_i;
        w_state_n = w_end ? S_IDLE : flush_i ? S_DRAIN : S_BUSY;
      end
      S_DRAIN: begin
        w_end = wb.wishbone_ack_i || w_tmo;
        w_state_n = w_end ? S_IDLE : S_DRAIN;
      end
      default: w_state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_idx <= '0;
      r_gnt <= '0;
      r_ack <= '0;
      r_addr <= '0;
      r_wdat <= '0;
      r_rdat <= '0;
      r_sel <= '0;
      r_we <= 1'b0;
      r_stb <= 1'b0;
    end else begin
      r_ack <= w_done ? r_gnt : '0;
      if (w_grant) begin
        r_idx <= w_idx;
        r_gnt <= w_gnt;
        r_addr <= ch_addr_i[w_idx*DATA_W +: DATA_W];
        r_wdat <= ch_data_i[w_idx*DATA_W +: DATA_W];
        r_sel <= ch_sel_i[w_idx*SW +: SW];
        r_we <= ch_we_i[w_idx];
        r_stb <= 1'b1;
      end
      if (w_end) begin
        r_stb <= 1'b0;
        r_ptr <= (r_idx == IW'(NUM_CH - 1)) ? '0 : r_idx + 1'b1;
      end
      if (w_done) r_rdat <= (wb.wishbone_ack_i && !r_we) ? wb.wishbone_data_i : '0;
    end
  end
`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_wdog;
  logic r_err;
  always_ff @(posedge clk) begin
    r_wdog <= (rst || w_grant) ? '0 : (r_state != S_IDLE) ? r_wdog + 1'b1 : r_wdog;
    r_err <= !rst && w_end && w_tmo && !wb.wishbone_ack_i;
  end
  assign w_tmo = (r_state != S_IDLE) && (r_wdog >= CW'(TIMEOUT_CYC - 1));
  assign err_o = r_err;
`else
  assign w_tmo = 1'b0;
  assign err_o = 1'b0;
`endif
  assign wb.wishbone_addr_o = r_addr;
  assign wb.wishbone_data_o = r_wdat;
  assign wb.wishbone_sel_o = r_sel;
  assign wb.wishbone_we_o = r_we;
  assign wb.wishbone_stb_o = r_stb;
  assign wb.wishbone_cyc_o = r_stb;
  assign ch_data_o = r_rdat;
  assign ch_ack_o = r_ack;
  assign ch_stall_o = ch_req_i & ~r_ack;
endmodule

// File: tb/tb_wb_master_arb.sv
// tb_wb_master_arb: directed scoreboard bench for wb_master_arb (NUM_CH=2, DATA_W=32).
// The timeout step runs only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_master_arb;
  typedef struct {
    logic [1:0]  ack;
    logic [31:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic [1:0] req = '0;
  logic [1:0] we = '0;
  logic [63:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [7:0] sel = '0;
  logic [31:0] ch_data;
  logic [1:0] ch_ack, ch_stall;
  logic err;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  wb_master_arb_if #(.DATA_W(32)) wb ();
  wb_master_arb #(.NUM_CH(2), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .ch_req_i(req), .ch_we_i(we),
    .ch_addr_i(addr), .ch_data_i(wdata), .ch_sel_i(sel), .ch_data_o(ch_data),
    .ch_ack_o(ch_ack), .ch_stall_o(ch_stall), .err_o(err), .wb(wb)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_ch(int ch, logic w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
    we[ch] = w;
    addr[ch*32 +: 32] = a;
    wdata[ch*32 +: 32] = d;
    sel[ch*4 +: 4] = s;
  endtask
  task automatic wait_stb(string tag, output int n);
    n = 0;
    while (!wb.wishbone_stb_o && n < 10) begin
      tick();
      n++;
    end
    chk(tag, wb.wishbone_stb_o, 1'b1);
  endtask
  task automatic pop_chk(string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s observed empty scoreboard expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_ack"}, ch_ack, e.ack);
      chk({tag, "_data"}, ch_data, e.data);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout observed hang expected finish");
    $fatal(1, "bench timeout");
  end
  initial begin
    int n;
    int ex;
    wb.wishbone_ack_i = 1'b0;
    wb.wishbone_data_i = '0;
    tick();
    tick();
    chk("rst_stb", wb.wishbone_stb_o, 0);
    chk("rst_cyc", wb.wishbone_cyc_o, 0);
    chk("rst_we", wb.wishbone_we_o, 0);
    chk("rst_addr", wb.wishbone_addr_o, 0);
    chk("rst_wdata", wb.wishbone_data_o, 0);
    chk("rst_sel", wb.wishbone_sel_o, 0);
    chk("rst_ack", ch_ack, 0);
    chk("rst_data", ch_data, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();
    chk("idle_noreq_stb", wb.wishbone_stb_o, 0);
    // ch0 read, zero-wait slave
    set_ch(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    req = 2'b01;
    sb.push_back('{2'b01, 32'hDEAD_BEEF});
    wait_stb("rd_stb", n);
    chk("rd_lat_grant", n, 1);
    chk("rd_addr", wb.wishbone_addr_o, 32'h100);
    chk("rd_we", wb.wishbone_we_o, 0);
    chk("rd_cyc", wb.wishbone_cyc_o, 1);
    wb.wishbone_ack_i = 1'b1;
    wb.wishbone_data_i = 32'hDEAD_BEEF;
    tick();
    wb.wishbone_ack_i = 1'b0;
    pop_chk("rd");
    chk("rd_stb_low", wb.wishbone_stb_o, 0);
    req = 2'b00;
    tick();
    chk("rd_ack_pulse", ch_ack, 0);
    // ch1 write
    set_ch(1, 1'b1, 32'h0000_0200, 32'h1234_5678, 4'b0011);
    req = 2'b10;
    sb.push_back('{2'b10, 32'h0});
    wait_stb("wr_stb", n);
    chk("wr_we", wb.wishbone_we_o, 1);
    chk("wr_sel", wb.wishbone_sel_o, 4'b0011);
    chk("wr_wdata", wb.wishbone_data_o, 32'h1234_5678);
    chk("wr_addr", wb.wishbone_addr_o, 32'h200);
    wb.wishbone_ack_i = 1'b1;
    wb.wishbone_data_i = 32'h5555_5555;
    tick();
    wb.wishbone_ack_i = 1'b0;
    pop_chk("wr");
    chk("wr_stall", ch_stall, 2'b00);
    req = 2'b00;
    tick();
    // both channels continuously requesting: grants alternate from pointer 0
    set_ch(0, 1'b0, 32'h0000_00A0, 32'h0, 4'hF);
    set_ch(1, 1'b0, 32'h0000_00B0, 32'h0, 4'hF);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      ex = k % 2;
      wait_stb("rr_stb", n);
      chk("rr_addr", wb.wishbone_addr_o, (ex == 0) ? 32'hA0 : 32'hB0);
      wb.wishbone_ack_i = 1'b1;
      wb.wishbone_data_i = 32'h1000 + k;
      sb.push_back('{2'(1 << ex), 32'h1000 + k});
      tick();
      wb.wishbone_ack_i = 1'b0;
      pop_chk("rr");
      chk("rr_stall", ch_stall, 2'b11 & ~2'(1 << ex));
      tick();
      chk("rr_no_regrant", wb.wishbone_stb_o, 0);
    end
    req = 2'b00;
    tick();
    // flush while BUSY, slave acks three cycles later
    set_ch(0, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
    req = 2'b01;
    wait_stb("fl_stb", n);
    flush = 1'b1;
    req = 2'b00;
    tick();
    flush = 1'b0;
    chk("fl_hold_stb", wb.wishbone_stb_o, 1);
    chk("fl_hold_cyc", wb.wishbone_cyc_o, 1);
    tick();
    chk("fl_hold_stb2", wb.wishbone_stb_o, 1);
    tick();
    chk("fl_hold_stb3", wb.wishbone_stb_o, 1);
    wb.wishbone_ack_i = 1'b1;
    tick();
    wb.wishbone_ack_i = 1'b0;
    chk("fl_drop_stb", wb.wishbone_stb_o, 0);
    chk("fl_drop_cyc", wb.wishbone_cyc_o, 0);
    chk("fl_no_ack", ch_ack, 0);
    tick();
    chk("fl_no_ack2", ch_ack, 0);
    chk("fl_idle_stb", wb.wishbone_stb_o, 0);
    // flush and ack together: flush wins (pointer is now 1)
    set_ch(1, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
    req = 2'b10;
    wait_stb("fa_stb", n);
    chk("fa_addr", wb.wishbone_addr_o, 32'h400);
    flush = 1'b1;
    wb.wishbone_ack_i = 1'b1;
    req = 2'b00;
    tick();
    flush = 1'b0;
    wb.wishbone_ack_i = 1'b0;
    chk("fa_no_ack", ch_ack, 0);
    chk("fa_stb", wb.wishbone_stb_o, 0);
    // flush in IDLE blocks the grant for that cycle
    set_ch(0, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
    req = 2'b01;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fi_no_grant", wb.wishbone_stb_o, 0);
    sb.push_back('{2'b01, 32'hCAFE_0007});
    tick();
    chk("fi_grant", wb.wishbone_stb_o, 1);
    chk("fi_addr", wb.wishbone_addr_o, 32'h500);
    wb.wishbone_ack_i = 1'b1;
    wb.wishbone_data_i = 32'hCAFE_0007;
    tick();
    wb.wishbone_ack_i = 1'b0;
    pop_chk("fi");
    req = 2'b00;
    tick();
    // reset mid-BUSY with pointer at 1; the late ack must be ignored
    set_ch(1, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
    set_ch(0, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
    req = 2'b10;
    wait_stb("rb_stb", n);
    chk("rb_addr", wb.wishbone_addr_o, 32'h600);
    rst = 1'b1;
    req = 2'b00;
    tick();
    rst = 1'b0;
    chk("rb_stb_low", wb.wishbone_stb_o, 0);
    chk("rb_cyc_low", wb.wishbone_cyc_o, 0);
    chk("rb_addr_clr", wb.wishbone_addr_o, 0);
    wb.wishbone_ack_i = 1'b1;
    wb.wishbone_data_i = 32'h9999_9999;
    tick();
    wb.wishbone_ack_i = 1'b0;
    chk("rb_ack_ignored", ch_ack, 0);
    chk("rb_data_clr", ch_data, 0);
    req = 2'b11;
    sb.push_back('{2'b01, 32'h0000_0077});
    wait_stb("rb_regrant", n);
    chk("rb_ptr0_addr", wb.wishbone_addr_o, 32'h700);
    wb.wishbone_ack_i = 1'b1;
    wb.wishbone_data_i = 32'h0000_0077;
    tick();
    wb.wishbone_ack_i = 1'b0;
    pop_chk("rb");
    req = 2'b00;
    tick();
`ifdef WB_ARB_TIMEOUT_EN
    // silent slave: watchdog ends the cycle after 8 BUSY cycles (pointer is now 1)
    set_ch(1, 1'b0, 32'h0000_0800, 32'h0, 4'hF);
    req = 2'b10;
    sb.push_back('{2'b10, 32'h0});
    wait_stb("to_stb", n);
    n = 0;
    while (wb.wishbone_stb_o && n < 20) begin
      n++;
      tick();
    end
    chk("to_busy_cycles", n, 8);
    chk("to_err", err, 1);
    pop_chk("to");
    req = 2'b00;
    tick();
    chk("to_err_pulse", err, 0);
`else
    chk("no_to_err", err, 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
